div_unit_seq: RTL
=================

// Module: div_unit_seq
// PURPOSE
//  Iterative radix-2 non-restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
//  It is the inverse-direction counterpart of the Booth multiplier datapath and
//  sits beside it in the EX-stage M-extension unit. It takes one request per
//  valid/ready handshake and returns quotient or remainder per RISC-V rules.
// PARAMETERS
//  XLEN      32   operand/result width (even, >=8)
// PORTS
//  i_clk       in   1      clock, rising edge
//  i_rst       in   1      async reset, active-high
//  i_valid     in   1      request valid
//  o_ready     out  1      unit can accept request (state IDLE)
//  i_op        in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//  i_dividend  in   XLEN   rs1
//  i_divisor   in   XLEN   rs2
//  i_flush     in   1      kill in-flight op (pipeline flush)
//  o_valid     out  1      result valid
//  i_ready     in   1      consumer accepts result
//  o_result    out  XLEN   quotient (DIV/DIVU) or remainder (REM/REMU)
// BEHAVIOUR
//  - Clock i_clk; reset i_rst async active-high. Reset: state=IDLE, o_valid=0,
//    o_ready=1, o_result=0, counter=0.
//  - Accept on edge with i_valid & o_ready. Latch op, |dividend|, |divisor| and
//    sign flags (signed ops only). Unsigned ops use operands unchanged.
//  - FSM IDLE->CALC->FIX->DONE->IDLE.
//    IDLE: o_ready=1. On accept, go to CALC, or DONE if a special case applies.
//    CALC: one quotient bit per cycle for XLEN cycles. 6-bit counter 0..XLEN-1.
//    FIX: one cycle. Restore the negative remainder. Quotient sign =
//      sign(a)^sign(b). Remainder sign = sign(a). Two's-complement negate.
//    DONE: o_valid=1, o_result stable. Go to IDLE on i_ready. i_valid is
//      ignored here (o_ready=0).
//  - Latency: normal op gives o_valid XLEN+2 edges after the accept edge.
//    A special case gives o_valid 1 edge after the accept edge.
//  - Special cases, resolved at accept with no iteration:
//    divisor==0: quotient = all ones, remainder = dividend (all ops).
//    Signed overflow (dividend = 2^(XLEN-1) as a negative value, divisor = -1):
//      DIV -> 2^(XLEN-1) bit pattern, REM -> 0.
//  - Arithmetic: partial remainder is XLEN+1 bits signed. Result truncates to
//    XLEN. |x| of most-negative is itself, treated as unsigned magnitude.
//  - Flush: i_flush in CALC/FIX/DONE goes to IDLE next edge with o_valid=0 and
//    discards the result. i_flush in IDLE blocks the accept that same cycle.
//    Flush has priority over i_ready.
//  - Backpressure: in DONE, o_result/o_valid hold indefinitely until i_ready.
//    No new accept before the DONE->IDLE edge, so there is no same-cycle
//    result-and-accept.
//  - Reset mid-operation aborts immediately to the reset values.
// STRUCTURE
//  - Shared package m_ext_pkg: typedef enum logic[1:0] div_op_t
//    {DIV,DIVU,REM,REMU}, typedef enum div_state_t {IDLE,CALC,FIX,DONE}.
//  - Sub-module div_step (combinational). Inputs: partial remainder, divisor,
//    next dividend bit. Outputs: new remainder and quotient bit
//    (add/sub by sign). Instanced once.
//  - Top holds the FSM, counter, operand/sign registers, special-case
//    detection and sign fix-up.
// TESTING
//  1 DIVU 100/7 -> o_result=14 exactly 34 cycles after accept; REMU same -> 2.
//  2 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1);
//    REM 7/-2 -> 1.
//  3 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; o_valid 1 cycle after accept.
//  4 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; 1-cycle latency.
//  5 i_ready low 10 cycles in DONE: o_result stable, o_ready=0, i_valid
//    ignored; back-to-back ops resume after release.
//  6 i_flush at CALC cycle 5 -> IDLE next edge, no o_valid. Next DIVU 9/3 -> 3.
//    i_rst mid-CALC -> all outputs at reset values.

Source files
------------

// File: rtl/m_ext_pkg.sv
// Shared types for the EX-stage M-extension unit: operation codes and the
// divider state encoding, plus small decode helpers.
package m_ext_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring iteration: shift in the next dividend bit, then
// add or subtract the divisor depending on the sign of the partial remainder.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            next_bit,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  assign shifted = {rem_in[XLEN-1:0], next_bit};

  // A negative remainder is repaired on the following step by adding instead
  // of restoring immediately; the true value always fits in XLEN+1 bits.
  assign rem_out = rem_in[XLEN] ? shifted + {1'b0, divisor}
                                : shifted - {1'b0, divisor};
  assign q_bit   = ~rem_out[XLEN];

endmodule

// File: rtl/div_unit_seq.sv
// Iterative radix-2 non-restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on magnitudes and applies RISC-V sign rules in a single fix-up cycle.
module div_unit_seq
  import m_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam logic [5:0]      LAST_CNT = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  logic [5:0]      cnt;
  logic            rem_sel_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   rem_q;

  div_op_t         op;
  logic            is_signed;
  logic            sign_a;
  logic            sign_b;
  logic            div_zero;
  logic            overflow;
  logic            accept;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] special_res;

  // Request decode; the most-negative value negates to itself, which is
  // exactly its unsigned magnitude.
  always_comb begin
    op          = div_op_t'(i_op);
    is_signed   = op_is_signed(op);
    sign_a      = is_signed & i_dividend[XLEN-1];
    sign_b      = is_signed & i_divisor[XLEN-1];
    mag_a       = sign_a ? -i_dividend : i_dividend;
    mag_b       = sign_b ? -i_divisor : i_divisor;
    div_zero    = (i_divisor == '0);
    overflow    = is_signed && (i_dividend == MIN_NEG) && (&i_divisor);
    accept      = i_valid & o_ready & ~i_flush;
    special_res = div_zero ? (op_is_rem(op) ? i_dividend : '1)
                           : (op_is_rem(op) ? '0 : MIN_NEG);
  end

  logic [XLEN:0] step_rem;
  logic          step_q;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in   (rem_q),
    .divisor  (dvs_q),
    .next_bit (quo_q[XLEN-1]),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  logic [XLEN-1:0] rem_mag;
  logic [XLEN-1:0] fix_res;

  always_comb begin
    rem_mag = rem_q[XLEN] ? rem_q[XLEN-1:0] + dvs_q : rem_q[XLEN-1:0];
    fix_res = rem_sel_q ? (neg_rem_q ? -rem_mag : rem_mag)
                        : (neg_quo_q ? -quo_q : quo_q);
  end

  // quo_q starts as the dividend magnitude and fills with quotient bits as
  // the dividend bits shift out of its top.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_result  <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_ready   <= 1'b0;
            rem_sel_q <= op_is_rem(op);
            neg_quo_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            if (div_zero || overflow) begin
              o_result <= special_res;
              o_valid  <= 1'b1;
              state    <= DONE;
            end else begin
              quo_q <= mag_a;
              dvs_q <= mag_b;
              rem_q <= '0;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            cnt     <= '0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            rem_q <= step_rem;
            quo_q <= {quo_q[XLEN-2:0], step_q};
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= FIX;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        FIX: begin
          if (i_flush) begin
            o_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            o_result <= fix_res;
            o_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_flush || i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
